// File: rtl/data_mem.sv
// MEM-stage data responder: byte-lane RAM plus CYCLE/GPIO/STATUS register window.
// Reads are combinational (0 cycles), writes commit at the edge (1 cycle); always ready, no backpressure.
module data_mem #(
    parameter int          ADDR_WIDTH = 10,
    parameter logic [31:0] MMIO_BASE  = 32'hFFFF_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] mem_addr,
    input  logic [3:0]  mem_byte_slct,
    input  logic [31:0] data_to_write_mem,
    input  logic        mem_we,
    input  logic        mem_re,
    output logic [31:0] data_from_mem,
    output logic [31:0] gpio_out,
    output logic        bus_error
);

    localparam int DEPTH = 1 << ADDR_WIDTH;

    typedef enum logic [1:0] {
        REG_CYCLE  = 2'd0,
        REG_GPIO   = 2'd1,
        REG_STATUS = 2'd2,
        REG_RSVD   = 2'd3
    } reg_sel_t;

    logic [31:0]           ram [DEPTH];
    logic [31:0]           cycle_cnt;
    logic [31:0]           gpio_reg;
    logic                  err_flag;

    logic                  ram_hit;
    logic                  mmio_hit;
    logic                  out_of_range;
    logic [ADDR_WIDTH-1:0] word_idx;
    reg_sel_t              reg_sel;
    logic                  wr_ram;
    logic                  wr_cycle;
    logic                  wr_gpio;
    logic                  status_clr;

    function automatic logic [31:0] lane_merge(
        input logic [31:0] old_word,
        input logic [31:0] new_word,
        input logic [3:0]  lanes
    );
        logic [31:0] merged;
        merged = old_word;
        for (int i = 0; i < 4; i++) begin
            if (lanes[i]) begin
                merged[8*i +: 8] = new_word[8*i +: 8];
            end
        end
        return merged;
    endfunction

    assign ram_hit      = (mem_addr >> (ADDR_WIDTH + 2)) == 32'd0;
    assign mmio_hit     = mem_addr[31:4] == MMIO_BASE[31:4];
    assign word_idx     = mem_addr[ADDR_WIDTH+1:2];
    assign reg_sel      = reg_sel_t'(mem_addr[3:2]);
    assign out_of_range = (mem_we || mem_re) && !ram_hit && !mmio_hit;

    assign wr_ram     = mem_we && ram_hit && !rst;
    assign wr_cycle   = mem_we && mmio_hit && (reg_sel == REG_CYCLE);
    assign wr_gpio    = mem_we && mmio_hit && (reg_sel == REG_GPIO);
    assign status_clr = mem_we && mmio_hit && (reg_sel == REG_STATUS)
                        && mem_byte_slct[0] && data_to_write_mem[0];

    // RAM has no reset; rst only suppresses writes issued while it is high.
    always_ff @(posedge clk) begin
        if (wr_ram) begin
            for (int i = 0; i < 4; i++) begin
                if (mem_byte_slct[i]) begin
                    ram[word_idx][8*i +: 8] <= data_to_write_mem[8*i +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cycle_cnt <= 32'd0;
            gpio_reg  <= 32'd0;
            err_flag  <= 1'b0;
        end else begin
            // Unwritten CYCLE lanes still advance, so a partial write never stalls the count.
            if (wr_cycle) begin
                cycle_cnt <= lane_merge(cycle_cnt + 32'd1, data_to_write_mem, mem_byte_slct);
            end else begin
                cycle_cnt <= cycle_cnt + 32'd1;
            end
            if (wr_gpio) begin
                gpio_reg <= lane_merge(gpio_reg, data_to_write_mem, mem_byte_slct);
            end
            if (out_of_range) begin
                err_flag <= 1'b1;
            end else if (status_clr) begin
                err_flag <= 1'b0;
            end
        end
    end

    always_comb begin
        data_from_mem = 32'd0;
        if (mem_re && !rst) begin
            if (ram_hit) begin
                data_from_mem = ram[word_idx];
            end else if (mmio_hit) begin
                case (reg_sel)
                    REG_CYCLE:  data_from_mem = cycle_cnt;
                    REG_GPIO:   data_from_mem = gpio_reg;
                    REG_STATUS: data_from_mem = {31'd0, err_flag};
                    default:    data_from_mem = 32'd0;
                endcase
            end
        end
    end

    assign gpio_out  = gpio_reg;
    assign bus_error = err_flag;

endmodule

// File: tb/tb_data_mem.sv
// Bench for data_mem: directed scenarios plus randomized traffic checked against a behavioural model.
module tb_data_mem;

    localparam int          AW   = 10;
    localparam logic [31:0] BASE = 32'hFFFF_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] mem_addr;
    logic [3:0]  mem_byte_slct;
    logic [31:0] data_to_write_mem;
    logic        mem_we;
    logic        mem_re;
    logic [31:0] data_from_mem;
    logic [31:0] gpio_out;
    logic        bus_error;

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    data_mem #(.ADDR_WIDTH(AW), .MMIO_BASE(BASE)) dut (
        .clk               (clk),
        .rst               (rst),
        .mem_addr          (mem_addr),
        .mem_byte_slct     (mem_byte_slct),
        .data_to_write_mem (data_to_write_mem),
        .mem_we            (mem_we),
        .mem_re            (mem_re),
        .data_from_mem     (data_from_mem),
        .gpio_out          (gpio_out),
        .bus_error         (bus_error)
    );

    // Reference model: 0 = RAM, 1..4 = window offsets 0x0..0xC, 5 = out of range.
    logic [31:0] m_ram [int];
    logic [31:0] m_cycle;
    logic [31:0] m_gpio;
    logic        m_err;

    function automatic int region(input logic [31:0] a);
        if (a < (32'd1 << (AW + 2))) return 0;
        if (a >= BASE && a - BASE < 32'd16) return 1 + int'((a - BASE) / 32'd4);
        return 5;
    endfunction

    function automatic logic [31:0] put_bytes(input logic [31:0] old_w, input logic [31:0] new_w,
                                              input logic [3:0] lanes);
        logic [31:0] r;
        r = old_w;
        for (int i = 0; i < 4; i++) if (lanes[i]) r[8*i +: 8] = new_w[8*i +: 8];
        return r;
    endfunction

    function automatic logic [31:0] m_read();
        int idx;
        if (rst || !mem_re) return 32'd0;
        case (region(mem_addr))
            0: begin
                idx = int'(mem_addr / 32'd4);
                if (m_ram.exists(idx)) return m_ram[idx];
                return 32'hxxxx_xxxx;
            end
            1: return m_cycle;
            2: return m_gpio;
            3: return {31'd0, m_err};
            default: return 32'd0;
        endcase
    endfunction

    always @(posedge clk) begin : model
        int          r;
        int          idx;
        logic [31:0] nxt;
        if (rst) begin
            m_cycle = 32'd0;
            m_gpio  = 32'd0;
            m_err   = 1'b0;
        end else begin
            r   = region(mem_addr);
            nxt = m_cycle + 32'd1;
            if (mem_we) begin
                case (r)
                    0: begin
                        idx = int'(mem_addr / 32'd4);
                        if (!m_ram.exists(idx)) m_ram[idx] = 32'hxxxx_xxxx;
                        m_ram[idx] = put_bytes(m_ram[idx], data_to_write_mem, mem_byte_slct);
                    end
                    1: nxt = put_bytes(nxt, data_to_write_mem, mem_byte_slct);
                    2: m_gpio = put_bytes(m_gpio, data_to_write_mem, mem_byte_slct);
                    3: if (mem_byte_slct[0] && data_to_write_mem[0]) m_err = 1'b0;
                    default: ;
                endcase
            end
            if ((mem_we || mem_re) && r == 5) m_err = 1'b1;
            m_cycle = nxt;
        end
    end

    task automatic drive(input logic [31:0] a, input logic [3:0] s, input logic [31:0] d,
                         input logic we, input logic re);
        mem_addr          = a;
        mem_byte_slct     = s;
        data_to_write_mem = d;
        mem_we            = we;
        mem_re            = re;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        drive(BASE, 4'h0, 32'd0, 1'b0, 1'b1);
        tick(); tick();
        n_cmp++; if (data_from_mem !== 32'd0) begin n_fail++; $display("FAIL reset_rdata: got %h want %h", data_from_mem, 32'd0); end
        n_cmp++; if (gpio_out !== 32'd0) begin n_fail++; $display("FAIL reset_gpio: got %h want %h", gpio_out, 32'd0); end
        n_cmp++; if (bus_error !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b want %b", bus_error, 1'b0); end
        drive(BASE + 32'd4, 4'hF, 32'hFFFF_FFFF, 1'b1, 1'b0);
        tick();
        n_cmp++; if (gpio_out !== 32'd0) begin n_fail++; $display("FAIL reset_wr_ignored: got %h want %h", gpio_out, 32'd0); end
        rst = 1'b0;
        drive(BASE, 4'h0, 32'd0, 1'b0, 1'b1);
        n_cmp++; if (data_from_mem !== 32'd0) begin n_fail++; $display("FAIL cycle_first: got %h want %h", data_from_mem, 32'd0); end
        tick();
        n_cmp++; if (data_from_mem !== 32'd1) begin n_fail++; $display("FAIL cycle_second: got %h want %h", data_from_mem, 32'd1); end
    endtask

    task automatic test_byte_lanes();
        drive(32'h10, 4'hF, 32'hAABB_CCDD, 1'b1, 1'b0); tick();
        drive(32'h10, 4'b0010, 32'h0000_1100, 1'b1, 1'b0); tick();
        drive(32'h10, 4'h0, 32'd0, 1'b0, 1'b1);
        n_cmp++; if (data_from_mem !== 32'hAABB_11DD) begin n_fail++; $display("FAIL lanes_0x10: got %h want %h", data_from_mem, 32'hAABB_11DD); end
        drive(32'h13, 4'h0, 32'd0, 1'b0, 1'b1);
        n_cmp++; if (data_from_mem !== 32'hAABB_11DD) begin n_fail++; $display("FAIL lanes_0x13: got %h want %h", data_from_mem, 32'hAABB_11DD); end
    endtask

    task automatic test_same_cycle();
        drive(32'h20, 4'hF, 32'h1, 1'b1, 1'b0); tick();
        drive(32'h20, 4'hF, 32'h2, 1'b1, 1'b1);
        n_cmp++; if (data_from_mem !== 32'h1) begin n_fail++; $display("FAIL rw_old: got %h want %h", data_from_mem, 32'h1); end
        tick();
        drive(32'h20, 4'h0, 32'd0, 1'b0, 1'b1);
        n_cmp++; if (data_from_mem !== 32'h2) begin n_fail++; $display("FAIL rw_new: got %h want %h", data_from_mem, 32'h2); end
    endtask

    task automatic test_cycle();
        drive(BASE, 4'hF, 32'hFFFF_FFFE, 1'b1, 1'b0); tick();
        drive(BASE, 4'h0, 32'd0, 1'b0, 1'b1);
        n_cmp++; if (data_from_mem !== 32'hFFFF_FFFE) begin n_fail++; $display("FAIL cycle_load: got %h want %h", data_from_mem, 32'hFFFF_FFFE); end
        tick();
        n_cmp++; if (data_from_mem !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL cycle_max: got %h want %h", data_from_mem, 32'hFFFF_FFFF); end
        tick();
        n_cmp++; if (data_from_mem !== 32'd0) begin n_fail++; $display("FAIL cycle_wrap: got %h want %h", data_from_mem, 32'd0); end
        drive(BASE, 4'hF, 32'h0000_01FE, 1'b1, 1'b0); tick();
        drive(BASE, 4'h0, 32'd0, 1'b0, 1'b1); tick();
        n_cmp++; if (data_from_mem !== 32'h0000_01FF) begin n_fail++; $display("FAIL cycle_pre: got %h want %h", data_from_mem, 32'h0000_01FF); end
        drive(BASE, 4'b0001, 32'h0000_0005, 1'b1, 1'b1); tick();
        drive(BASE, 4'h0, 32'd0, 1'b0, 1'b1);
        n_cmp++; if (data_from_mem !== 32'h0000_0205) begin n_fail++; $display("FAIL cycle_merge: got %h want %h", data_from_mem, 32'h0000_0205); end
    endtask

    task automatic test_out_of_range();
        drive(32'h0000_1000, 4'h0, 32'd0, 1'b0, 1'b1);
        n_cmp++; if (data_from_mem !== 32'd0) begin n_fail++; $display("FAIL oor_rdata: got %h want %h", data_from_mem, 32'd0); end
        n_cmp++; if (bus_error !== 1'b0) begin n_fail++; $display("FAIL oor_not_yet: got %b want %b", bus_error, 1'b0); end
        tick();
        drive(BASE + 32'd8, 4'h0, 32'd0, 1'b0, 1'b1);
        n_cmp++; if (bus_error !== 1'b1) begin n_fail++; $display("FAIL oor_set: got %b want %b", bus_error, 1'b1); end
        n_cmp++; if (data_from_mem !== 32'd1) begin n_fail++; $display("FAIL status_read: got %h want %h", data_from_mem, 32'd1); end
        drive(BASE + 32'd8, 4'b0001, 32'h1, 1'b1, 1'b0); tick();
        n_cmp++; if (bus_error !== 1'b0) begin n_fail++; $display("FAIL status_clear: got %b want %b", bus_error, 1'b0); end
        drive(32'h0000_1000, 4'hF, 32'hFFFF_FFFF, 1'b1, 1'b0); tick();
        drive(BASE + 32'd8, 4'b0001, 32'hFFFF_FFFE, 1'b1, 1'b0); tick();
        n_cmp++; if (bus_error !== 1'b1) begin n_fail++; $display("FAIL status_bit0_zero: got %b want %b", bus_error, 1'b1); end
        drive(BASE + 32'd8, 4'b1110, 32'hFFFF_FFFF, 1'b1, 1'b0); tick();
        n_cmp++; if (bus_error !== 1'b1) begin n_fail++; $display("FAIL status_lane0_off: got %b want %b", bus_error, 1'b1); end
        drive(BASE + 32'd8, 4'b0001, 32'h1, 1'b1, 1'b0); tick();
        drive(BASE + 32'hC, 4'hF, 32'hFFFF_FFFF, 1'b1, 1'b1);
        n_cmp++; if (data_from_mem !== 32'd0) begin n_fail++; $display("FAIL rsvd_read: got %h want %h", data_from_mem, 32'd0); end
        tick();
        n_cmp++; if (bus_error !== 1'b0) begin n_fail++; $display("FAIL rsvd_no_err: got %b want %b", bus_error, 1'b0); end
        drive(32'h8000_0000, 4'h0, 32'd0, 1'b0, 1'b1); tick();
        drive(BASE + 32'd8, 4'b0001, 32'h1, 1'b1, 1'b0); tick();
        drive(BASE + 32'h10, 4'h0, 32'd0, 1'b0, 1'b1);
        n_cmp++; if (bus_error !== 1'b0) begin n_fail++; $display("FAIL clear_then_oor_mid: got %b want %b", bus_error, 1'b0); end
        tick();
        n_cmp++; if (bus_error !== 1'b1) begin n_fail++; $display("FAIL clear_then_oor: got %b want %b", bus_error, 1'b1); end
    endtask

    task automatic test_gpio_reset();
        drive(BASE + 32'd4, 4'hF, 32'hDEAD_BEEF, 1'b1, 1'b0); tick();
        n_cmp++; if (gpio_out !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL gpio_write: got %h want %h", gpio_out, 32'hDEAD_BEEF); end
        drive(32'h40, 4'hF, 32'h0BAD_F00D, 1'b1, 1'b0); tick();
        rst = 1'b1;
        drive(BASE + 32'd4, 4'hF, 32'h1234_5678, 1'b1, 1'b0); tick();
        n_cmp++; if (gpio_out !== 32'd0) begin n_fail++; $display("FAIL gpio_rst: got %h want %h", gpio_out, 32'd0); end
        n_cmp++; if (bus_error !== 1'b0) begin n_fail++; $display("FAIL err_rst: got %b want %b", bus_error, 1'b0); end
        drive(32'h40, 4'hF, 32'h1111_1111, 1'b1, 1'b1);
        n_cmp++; if (data_from_mem !== 32'd0) begin n_fail++; $display("FAIL rst_rdata: got %h want %h", data_from_mem, 32'd0); end
        tick();
        rst = 1'b0;
        drive(32'h40, 4'h0, 32'd0, 1'b0, 1'b1);
        n_cmp++; if (data_from_mem !== 32'h0BAD_F00D) begin n_fail++; $display("FAIL ram_rst_write: got %h want %h", data_from_mem, 32'h0BAD_F00D); end
    endtask

    task automatic test_idle();
        for (int i = 0; i < 8; i++) begin
            drive($urandom, 4'($urandom), $urandom, 1'b0, 1'b0);
            n_cmp++; if (data_from_mem !== 32'd0) begin n_fail++; $display("FAIL idle_rdata: got %h want %h", data_from_mem, 32'd0); end
            tick();
        end
        n_cmp++; if (bus_error !== 1'b0) begin n_fail++; $display("FAIL idle_err: got %b want %b", bus_error, 1'b0); end
        n_cmp++; if (gpio_out !== 32'd0) begin n_fail++; $display("FAIL idle_gpio: got %h want %h", gpio_out, 32'd0); end
        drive(32'h10, 4'h0, 32'hFFFF_FFFF, 1'b1, 1'b0); tick();
        drive(32'h10, 4'h0, 32'd0, 1'b0, 1'b1);
        n_cmp++; if (data_from_mem !== 32'hAABB_11DD) begin n_fail++; $display("FAIL slct0_ram: got %h want %h", data_from_mem, 32'hAABB_11DD); end
        n_cmp++; if (bus_error !== 1'b0) begin n_fail++; $display("FAIL slct0_err: got %b want %b", bus_error, 1'b0); end
    endtask

    task automatic test_random();
        logic [31:0] a;
        logic [31:0] exp;
        int          kind;
        for (int i = 0; i < 16; i++) begin
            drive(32'h100 + 32'(4 * i), 4'hF, $urandom, 1'b1, 1'b0); tick();
        end
        for (int n = 0; n < 400; n++) begin
            kind = $urandom_range(0, 9);
            if (kind <= 5)      a = 32'h100 + 32'($urandom_range(0, 63));
            else if (kind <= 8) a = BASE + 32'($urandom_range(0, 15));
            else if ($urandom_range(0, 1) == 0) a = 32'h1000 + 32'($urandom_range(0, 65535));
            else                a = BASE + 32'h10 + 32'($urandom_range(0, 255));
            drive(a, 4'($urandom), $urandom, 1'($urandom), 1'($urandom));
            exp = m_read();
            if (!$isunknown(exp)) begin
                n_cmp++; if (data_from_mem !== exp) begin n_fail++; $display("FAIL rand_rdata @%h: got %h want %h", a, data_from_mem, exp); end
            end
            n_cmp++; if (gpio_out !== m_gpio) begin n_fail++; $display("FAIL rand_gpio: got %h want %h", gpio_out, m_gpio); end
            n_cmp++; if (bus_error !== m_err) begin n_fail++; $display("FAIL rand_err: got %b want %b", bus_error, m_err); end
            tick();
        end
    endtask

    initial begin
        rst = 1'b1;
        mem_addr = 32'd0; mem_byte_slct = 4'h0; data_to_write_mem = 32'd0;
        mem_we = 1'b0; mem_re = 1'b0;
        test_reset();
        test_byte_lanes();
        test_same_cycle();
        test_cycle();
        test_out_of_range();
        test_gpio_reset();
        test_idle();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
